// File: rtl/pwm_decoder.sv
// pwm_decoder: measures an incoming PWM waveform.
// Reports period (rise to rise), high time (rise to fall) and a 4-bit level
// recovered from the high time. It also flags a line that stops toggling.
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-low reset
//   pwm_in     - asynchronous PWM line
//   period     - last measured period in cycles
//   high_time  - last measured high time in cycles
//   level      - sat15(high_time >> LVL_SHIFT); forced to 15/0 on stuck high/low
//   valid      - one-cycle pulse when period/high_time/level update
//   stuck      - no rising edge seen for TIMEOUT cycles
//   stuck_high - synchronized line value when stuck asserted
module pwm_decoder #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TIMEOUT   = 200,
    parameter int unsigned LVL_SHIFT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [3:0]       level,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_high
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LVL_MAX   = CNT_W'(15);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             pwm_s_q, pwm_s_d;
    logic             pwm_d_q, pwm_d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_tmp_q, hi_tmp_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [3:0]       level_q, level_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             stuck_high_q, stuck_high_d;

    logic             rise, fall, timeout;
    logic [CNT_W-1:0] shifted;
    logic [3:0]       lvl_sat;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            pwm_s_q      <= 1'b0;
            pwm_d_q      <= 1'b0;
            cnt_q        <= '0;
            hi_tmp_q     <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            level_q      <= 4'd0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            stuck_high_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            pwm_s_q      <= pwm_s_d;
            pwm_d_q      <= pwm_d_d;
            cnt_q        <= cnt_d;
            hi_tmp_q     <= hi_tmp_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            level_q      <= level_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
            stuck_high_q <= stuck_high_d;
        end
    end

    // Next-state and measurement logic
    always_comb begin
        sync1_d      = pwm_in;
        pwm_s_d      = sync1_q;
        pwm_d_d      = pwm_s_q;
        state_d      = state_q;
        hi_tmp_d     = hi_tmp_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        level_d      = level_q;
        valid_d      = 1'b0;
        stuck_d      = stuck_q;
        stuck_high_d = stuck_high_q;

        rise    = pwm_s_q & ~pwm_d_q;
        fall    = ~pwm_s_q & pwm_d_q;
        // A rise on the timeout cycle wins, so a period of exactly TIMEOUT is legal
        timeout = (cnt_q == TIMEOUT_C) & ~rise;
        shifted = hi_tmp_q >> LVL_SHIFT;
        lvl_sat = (shifted > LVL_MAX) ? 4'd15 : shifted[3:0];

        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (rise) begin
            stuck_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    hi_tmp_d = cnt_q;
                    state_d  = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    period_d    = cnt_q;
                    high_time_d = hi_tmp_q;
                    level_d     = lvl_sat;
                    valid_d     = 1'b1;
                    state_d     = HIGH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Stuck line: level pinned to the rail the line is stuck at
        if (timeout) begin
            stuck_d      = 1'b1;
            stuck_high_d = pwm_s_q;
            level_d      = pwm_s_q ? 4'd15 : 4'd0;
            state_d      = IDLE;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign level      = level_q;
    assign valid      = valid_q;
    assign stuck      = stuck_q;
    assign stuck_high = stuck_high_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Scoreboard bench for pwm_decoder: stimulus pushes the expected measurement
// of each completed period; a negedge monitor pops it whenever valid pulses.
module tb_pwm_decoder;

    logic       clock;
    logic       reset;
    logic       pwm_in;
    logic [7:0] period;
    logic [7:0] high_time;
    logic [3:0] level;
    logic       valid;
    logic       stuck;
    logic       stuck_high;

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] h;
        logic [3:0] l;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Previous full pulse, reported on the next rise
    bit   have_prev = 0;
    int   prev_p, prev_h, prev_l;

    pwm_decoder #(.CNT_W(8), .TIMEOUT(200), .LVL_SHIFT(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .level      (level),
        .valid      (valid),
        .stuck      (stuck),
        .stuck_high (stuck_high)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One PWM period: high h cycles, then low p-h cycles; lvl is hand-computed
    task automatic pulse(input int h, input int p, input int lvl);
        exp_t e;
        if (have_prev) begin
            e.p = 8'(prev_p);
            e.h = 8'(prev_h);
            e.l = 4'(prev_l);
            exp_q.push_back(e);
        end
        pwm_in = 1'b1;
        wait_cyc(h);
        pwm_in = 1'b0;
        wait_cyc(p - h);
        have_prev = 1;
        prev_p = p;
        prev_h = h;
        prev_l = lvl;
    endtask

    task automatic flush_prev();
        exp_t e;
        if (have_prev) begin
            e.p = 8'(prev_p);
            e.h = 8'(prev_h);
            e.l = 4'(prev_l);
            exp_q.push_back(e);
        end
        have_prev = 0;
    endtask

    // Monitor
    always @(negedge clock) begin
        if (valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got period=%0d high=%0d level=%0d expected no valid",
                         period, high_time, level);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("valid_period", int'(period), int'(e.p));
                chk("valid_high_time", int'(high_time), int'(e.h));
                chk("valid_level", int'(level), int'(e.l));
            end
        end
    end

    initial begin
        reset  = 1'b0;
        pwm_in = 1'b0;

        // Reset held, line low
        wait_cyc(10);
        chk("rst_period", int'(period), 0);
        chk("rst_high_time", int'(high_time), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_stuck", int'(stuck), 0);
        chk("rst_stuck_high", int'(stuck_high), 0);
        reset = 1'b1;

        wait_cyc(150);
        chk("low_pre_timeout_stuck", int'(stuck), 0);
        wait_cyc(60);
        chk("low_stuck", int'(stuck), 1);
        chk("low_stuck_high", int'(stuck_high), 0);
        chk("low_stuck_level", int'(level), 0);

        // Generator waveform, then high-time changes
        pulse(6, 100, 3);
        chk("stuck_clear_on_rise", int'(stuck), 0);
        pulse(6, 100, 3);
        pulse(6, 100, 3);
        pulse(30, 100, 15);
        pulse(40, 100, 15);
        pulse(6, 100, 3);

        // Line stuck high mid-stream
        flush_prev();
        pwm_in = 1'b1;
        wait_cyc(250);
        chk("hi_stuck", int'(stuck), 1);
        chk("hi_stuck_high", int'(stuck_high), 1);
        chk("hi_stuck_level", int'(level), 15);
        chk("hi_stuck_period_hold", int'(period), 100);
        chk("hi_stuck_high_time_hold", int'(high_time), 6);
        pwm_in = 1'b0;
        wait_cyc(50);
        pulse(6, 100, 3);
        chk("hi_stuck_cleared", int'(stuck), 0);
        pulse(6, 100, 3);

        // Reset during a high phase
        flush_prev();
        pwm_in = 1'b1;
        wait_cyc(10);
        reset = 1'b0;
        #1;
        chk("midrst_period", int'(period), 0);
        chk("midrst_high_time", int'(high_time), 0);
        chk("midrst_level", int'(level), 0);
        chk("midrst_valid", int'(valid), 0);
        @(negedge clock);
        reset  = 1'b1;
        pwm_in = 1'b0;
        wait_cyc(50);
        pulse(6, 100, 3);
        pulse(6, 100, 3);
        pulse(8, 100, 4);

        // Period exactly TIMEOUT: rise wins over timeout
        pulse(6, 200, 3);
        pulse(6, 100, 3);
        chk("period200_no_stuck", int'(stuck), 0);

        wait_cyc(20);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
